// File: rtl/regfile_operand_fetch_if.sv
// Signal bundle for the operand-fetch stage: the decode, writeback, register-file and execute sides.
// The master modport is the fetch stage. The slave modport is its surroundings.
interface regfile_operand_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 8
);
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic [ADDR_W-1:0] id_rd;
  logic [CTRL_W-1:0] id_ctrl;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              rf_enable;
  logic              rf_read_write;
  logic [ADDR_W-1:0] rf_rs1;
  logic [ADDR_W-1:0] rf_rs2;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_din;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [ADDR_W-1:0] op_rd;
  logic [CTRL_W-1:0] op_ctrl;

  modport master (
    input  id_valid, id_rs1, id_rs2, id_rd, id_ctrl,
    output id_ready,
    input  wb_valid, wb_rd, wb_data,
    output rf_enable, rf_read_write, rf_rs1, rf_rs2, rf_rd, rf_din,
    input  rf_a, rf_b,
    output op_valid, op_a, op_b, op_rd, op_ctrl,
    input  op_ready
  );

  modport slave (
    output id_valid, id_rs1, id_rs2, id_rd, id_ctrl,
    input  id_ready,
    output wb_valid, wb_rd, wb_data,
    input  rf_enable, rf_read_write, rf_rs1, rf_rs2, rf_rd, rf_din,
    output rf_a, rf_b,
    input  op_valid, op_a, op_b, op_rd, op_ctrl,
    output op_ready
  );
endinterface

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage: issues register-file reads and writeback writes, and forwards writeback data.
// It presents the operands to execute on a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for decode; a writeback that cycle blocks the read
// CAPTURE | register file output valid; load operands with forwarding
// OUT     | operands presented to execute; late writebacks still forwarded
module regfile_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 8
) (
  input  logic clock,
  input  logic reset,
  regfile_operand_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, OUT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              op_valid_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [ADDR_W-1:0] op_rd_q;
  logic [CTRL_W-1:0] op_ctrl_q;

  logic wb_write;
  logic id_ready_c;
  logic accept;

  assign wb_write   = bus.wb_valid && (bus.wb_rd != '0);
  assign id_ready_c = (state == IDLE) && !bus.wb_valid;
  assign accept     = bus.id_valid && id_ready_c;

  assign bus.id_ready      = id_ready_c;
  assign bus.rf_enable     = wb_write || accept;
  assign bus.rf_read_write = wb_write;
  assign bus.rf_rs1        = accept ? bus.id_rs1 : '0;
  assign bus.rf_rs2        = accept ? bus.id_rs2 : '0;
  assign bus.rf_rd         = wb_write ? bus.wb_rd : '0;
  assign bus.rf_din        = wb_write ? bus.wb_data : '0;

  assign bus.op_valid = op_valid_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.op_rd    = op_rd_q;
  assign bus.op_ctrl  = op_ctrl_q;

  // x0 reads as zero regardless of the register file or any writeback.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [ADDR_W-1:0] idx,
    input logic              wb_v,
    input logic [ADDR_W-1:0] wb_idx,
    input logic [DATA_W-1:0] wb_val,
    input logic [DATA_W-1:0] rf_val
  );
    if (idx == '0)
      return '0;
    else if (wb_v && (wb_idx == idx))
      return wb_val;
    else
      return rf_val;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_ctrl_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rs1_q  <= bus.id_rs1;
            rs2_q  <= bus.id_rs2;
            rd_q   <= bus.id_rd;
            ctrl_q <= bus.id_ctrl;
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          op_a_q     <= pick_operand(rs1_q, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.rf_a);
          op_b_q     <= pick_operand(rs2_q, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.rf_b);
          op_rd_q    <= rd_q;
          op_ctrl_q  <= ctrl_q;
          op_valid_q <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          // Youngest writeback wins while execute is stalled.
          if (wb_write && (bus.wb_rd == rs1_q))
            op_a_q <= bus.wb_data;
          if (wb_write && (bus.wb_rd == rs2_q))
            op_b_q <= bus.wb_data;
          if (bus.op_ready) begin
            op_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: behavioural 32x32 register file, directed vectors,
// and a scoreboard that is checked at each execute handshake.
module tb_regfile_operand_fetch;

  logic clock = 1'b0;
  logic reset = 1'b0;

  regfile_operand_fetch_if #(.DATA_W(32), .ADDR_W(5), .CTRL_W(8)) bus ();

  regfile_operand_fetch #(.DATA_W(32), .ADDR_W(5), .CTRL_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [31:0] mem [32];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    bus.rf_a = '0;
    bus.rf_b = '0;
  end

  // Register file with a one-cycle registered read.
  always @(posedge clock) begin
    if (bus.rf_enable && bus.rf_read_write && bus.rf_rd != 5'd0)
      mem[bus.rf_rd] <= bus.rf_din;
    if (bus.rf_enable && !bus.rf_read_write) begin
      bus.rf_a <= mem[bus.rf_rs1];
      bus.rf_b <= mem[bus.rf_rs2];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset && bus.op_valid && bus.op_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_op", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_op_a", bus.op_a, e.a);
        chk("sb_op_b", bus.op_b, e.b);
        chk("sb_op_rd", {27'd0, bus.op_rd}, {27'd0, e.rd});
        chk("sb_op_ctrl", {24'd0, bus.op_ctrl}, {24'd0, e.ctrl});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb_set(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
  endtask

  task automatic wb_clr();
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
  endtask

  // Drives one instruction until accepted; returns in the CAPTURE cycle.
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [7:0] ctrl, input logic [31:0] ea, input logic [31:0] eb,
                       input bit push);
    int n;
    exp_t e;
    bus.id_valid = 1'b1;
    bus.id_rs1   = rs1;
    bus.id_rs2   = rs2;
    bus.id_rd    = rd;
    bus.id_ctrl  = ctrl;
    n = 0;
    @(negedge clock);
    while (!bus.id_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("accept_id_ready", {31'd0, bus.id_ready}, 32'd1);
    chk("read_rf_rs1", {27'd0, bus.rf_rs1}, {27'd0, rs1});
    if (push) begin
      e.a = ea; e.b = eb; e.rd = rd; e.ctrl = ctrl;
      sb_q.push_back(e);
    end
    tick();
    bus.id_valid = 1'b0;
  endtask

  // From CAPTURE, checks the latency of two cycles, with an optional writeback during CAPTURE.
  task automatic finish_read(input bit wb, input logic [4:0] wrd, input logic [31:0] wdata);
    if (wb) wb_set(wrd, wdata);
    @(negedge clock);
    chk("lat_capture_op_valid", {31'd0, bus.op_valid}, 32'd0);
    tick();
    wb_clr();
    @(negedge clock);
    chk("lat_out_op_valid", {31'd0, bus.op_valid}, 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_valid = 1'b0;
    bus.id_rs1   = '0;
    bus.id_rs2   = '0;
    bus.id_rd    = '0;
    bus.id_ctrl  = '0;
    bus.op_ready = 1'b1;
    wb_clr();

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
    chk("rst_op_a", bus.op_a, 32'd0);
    chk("rst_id_ready", {31'd0, bus.id_ready}, 32'd1);
    chk("rst_rf_enable", {31'd0, bus.rf_enable}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // x5 = 0xAA, then read rs1=5, rs2=0
    wb_set(5'd5, 32'h0000_00AA);
    @(negedge clock);
    chk("wb_rf_enable", {31'd0, bus.rf_enable}, 32'd1);
    chk("wb_rf_read_write", {31'd0, bus.rf_read_write}, 32'd1);
    chk("wb_rf_rd", {27'd0, bus.rf_rd}, 32'd5);
    chk("wb_rf_din", bus.rf_din, 32'h0000_00AA);
    tick();
    wb_clr();
    issue(5'd5, 5'd0, 5'd9, 8'h3C, 32'h0000_00AA, 32'd0, 1'b1);
    finish_read(1'b0, '0, '0);

    // Writeback collides with decode in IDLE: the write goes first, and the read follows.
    bus.id_valid = 1'b1;
    bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd5; bus.id_rd = 5'd1; bus.id_ctrl = 8'h11;
    wb_set(5'd3, 32'h0000_1234);
    @(negedge clock);
    chk("coll_id_ready", {31'd0, bus.id_ready}, 32'd0);
    chk("coll_rf_read_write", {31'd0, bus.rf_read_write}, 32'd1);
    chk("coll_rf_enable", {31'd0, bus.rf_enable}, 32'd1);
    tick();
    wb_clr();
    issue(5'd3, 5'd5, 5'd1, 8'h11, 32'h0000_1234, 32'h0000_00AA, 1'b1);
    finish_read(1'b0, '0, '0);

    // Writeback to x7 during CAPTURE is forwarded over the stale register-file value.
    issue(5'd7, 5'd3, 5'd4, 8'h22, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    finish_read(1'b1, 5'd7, 32'hDEAD_BEEF);

    // A writeback that matches both sources forwards to both operands.
    issue(5'd6, 5'd6, 5'd6, 8'h66, 32'h0000_CAFE, 32'h0000_CAFE, 1'b1);
    finish_read(1'b1, 5'd6, 32'h0000_CAFE);

    // Execute stalls in OUT, and a writeback to x2 updates op_b.
    bus.op_ready = 1'b0;
    issue(5'd5, 5'd2, 5'd12, 8'h5A, 32'h0000_00AA, 32'h0000_0055, 1'b1);
    tick();
    @(negedge clock);
    chk("stall_op_valid_0", {31'd0, bus.op_valid}, 32'd1);
    chk("stall_op_b_pre", bus.op_b, 32'd0);
    tick();
    wb_set(5'd2, 32'h0000_0055);
    tick();
    wb_clr();
    @(negedge clock);
    chk("stall_op_b_fwd", bus.op_b, 32'h0000_0055);
    chk("stall_op_a", bus.op_a, 32'h0000_00AA);
    chk("stall_op_valid_2", {31'd0, bus.op_valid}, 32'd1);
    chk("stall_op_rd", {27'd0, bus.op_rd}, 32'd12);
    chk("stall_op_ctrl", {24'd0, bus.op_ctrl}, 32'h5A);
    tick();
    @(negedge clock);
    chk("stall_op_valid_3", {31'd0, bus.op_valid}, 32'd1);
    bus.op_ready = 1'b1;
    tick();
    @(negedge clock);
    chk("release_op_valid", {31'd0, bus.op_valid}, 32'd0);
    tick();

    // Writeback to x0: no write is issued, but the writeback still blocks the read. x0 reads zero even with a forward.
    wb_set(5'd0, 32'hFFFF_FFFF);
    @(negedge clock);
    chk("x0_rf_enable", {31'd0, bus.rf_enable}, 32'd0);
    chk("x0_id_ready", {31'd0, bus.id_ready}, 32'd0);
    tick();
    wb_clr();
    issue(5'd0, 5'd5, 5'd3, 8'h77, 32'd0, 32'h0000_00AA, 1'b1);
    finish_read(1'b1, 5'd0, 32'hFFFF_FFFF);

    // Reset while in OUT clears the outputs without waiting for a clock edge.
    bus.op_ready = 1'b0;
    issue(5'd7, 5'd5, 5'd15, 8'hA5, 32'd0, 32'd0, 1'b0);
    tick();
    @(negedge clock);
    chk("pre_rst_op_valid", {31'd0, bus.op_valid}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
    chk("async_rst_op_a", bus.op_a, 32'd0);
    chk("async_rst_op_b", bus.op_b, 32'd0);
    chk("async_rst_op_rd", {27'd0, bus.op_rd}, 32'd0);
    chk("async_rst_op_ctrl", {24'd0, bus.op_ctrl}, 32'd0);
    tick();
    reset = 1'b1;
    bus.op_ready = 1'b1;
    @(negedge clock);
    chk("post_rst_id_ready", {31'd0, bus.id_ready}, 32'd1);
    tick();

    // The register file contents survive the reset of the fetch stage.
    issue(5'd7, 5'd2, 5'd1, 8'hF0, 32'hDEAD_BEEF, 32'h0000_0055, 1'b1);
    finish_read(1'b0, '0, '0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Operand-fetch stage sitting between decode and execute; it is the only block that drives the 32x32 register file's control inputs.
- Accepts decoded instructions over a valid/ready handshake and issues the one-cycle registered read.
- Captures the returned A/B operands, forwards any in-flight writeback to the same register, and presents the operands to execute over a valid/ready handshake.
- Also issues writeback writes to the register file; writes have priority over reads.

Parameters:
- DATA_W, 32, operand/writeback data width
- ADDR_W, 5, register index width
- CTRL_W, 8, opaque decode control bits carried through to execute

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- id_valid  input  1  decode presents an instruction
- id_ready  output  1  stage accepts the instruction this cycle
- id_rs1  input  ADDR_W  source register 1 index
- id_rs2  input  ADDR_W  source register 2 index
- id_rd  input  ADDR_W  destination index, carried through
- id_ctrl  input  CTRL_W  control bits, carried through
- wb_valid  input  1  writeback request; no backpressure
- wb_rd  input  ADDR_W  writeback destination
- wb_data  input  DATA_W  writeback value
- rf_enable  output  1  to register file enable
- rf_read_write  output  1  1 = write, 0 = read
- rf_rs1  output  ADDR_W  register file read index 1
- rf_rs2  output  ADDR_W  register file read index 2
- rf_rd  output  ADDR_W  register file write index
- rf_din  output  DATA_W  register file write data
- rf_a  input  DATA_W  register file A output (registered, valid the cycle after the read)
- rf_b  input  DATA_W  register file B output
- op_valid  output  1  operands valid for execute
- op_ready  input  1  execute accepts the operands
- op_a  output  DATA_W  operand 1
- op_b  output  DATA_W  operand 2
- op_rd  output  ADDR_W  carried destination index
- op_ctrl  output  CTRL_W  carried control bits

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; op_valid=0; op_a, op_b, op_rd, op_ctrl=0; captured rs1/rs2=0.
- Register-file control outputs are combinational from state and inputs.
- rf_enable=0 whenever no request is issued.
- Write path:
  - wb_valid=1 and wb_rd!=0, any state: rf_enable=1, rf_read_write=1, rf_rd=wb_rd, rf_din=wb_data.
  - wb_valid=1 and wb_rd==0: no write is issued (x0 is hardwired to 0); wb_valid still blocks a read that cycle.
- FSM states: IDLE, CAPTURE, OUT.
- IDLE:
  - id_ready = !wb_valid.
  - On id_valid && id_ready: rf_enable=1, rf_read_write=0, rf_rs1=id_rs1, rf_rs2=id_rs2.
  - Same cycle, latch rs1, rs2, rd, ctrl; go to CAPTURE.
- CAPTURE:
  - id_ready=0.
  - rf_a/rf_b are valid this cycle.
  - At the clock edge, load op_a and op_b, then go to OUT.
  - Load rule for each operand, applied in priority order:
    - captured index==0 → 0;
    - else wb_valid && wb_rd==index → wb_data (forward);
    - else rf_a / rf_b.
  - op_rd and op_ctrl take the latched values.
- OUT:
  - op_valid=1; id_ready=0.
  - Each cycle, if wb_valid && wb_rd!=0 && wb_rd matches a captured source, that operand is overwritten with wb_data (youngest writeback wins).
  - On op_valid && op_ready: op_valid deasserts next cycle; go to IDLE.
  - Outputs stay stable while op_ready=0, except for forwarding overwrites.
- Latency: accept at cycle T → op_valid=1 at cycle T+2. Maximum throughput is one instruction per 3 cycles. No back-to-back accept from OUT.
- Simultaneous events:
  - wb_valid with id_valid in IDLE: the write is issued and id_ready=0; the read is issued on the next free cycle.
  - wb_rd matching both sources: both operands are forwarded.
- Reset mid-operation: the in-flight instruction is dropped, op_valid falls immediately, and the FSM returns to IDLE.

Test Plan:
- Reset release, write x5=0x0000_00AA, then read rs1=5, rs2=0 → op_valid at T+2, op_a=0xAA, op_b=0.
- id_valid and wb_valid (x3=0x1234) in the same IDLE cycle → id_ready=0, rf_read_write=1 that cycle; read issued next cycle; later read of x3 returns 0x1234.
- Read rs1=7; in CAPTURE, wb x7=0xDEAD_BEEF → op_a=0xDEADBEEF (forwarded, not the stale register file value).
- Hold op_ready=0 for 4 cycles in OUT; wb x2=0x55 arrives with rs2=2 → op_b updates to 0x55; op_valid stays 1; op_rd/op_ctrl unchanged.
- Writeback to x0 with 0xFFFF_FFFF → rf_enable=0 that cycle; later read of rs1=0 → op_a=0.
- Assert reset low while in OUT → op_valid=0 and all op_* outputs=0 asynchronously; after release id_ready=1.
